// File: rtl/shared_sqscmul_seq_if.sv
// Operand, randomness, datapath and result bundle of the shared square-scale-multiply sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface shared_sqscmul_seq_if #(
    parameter int SHARES = 4
);
    localparam int DW = 4 * SHARES;
    localparam int ZW = 2 * SHARES * (SHARES - 1);

    logic          InValidxSI;
    logic          InReadyxSO;
    logic [DW-1:0] InXxDI;
    logic [DW-1:0] InYxDI;
    logic          RandValidxSI;
    logic          RandReadyxSO;
    logic [ZW-1:0] RandZxDI;
    logic [DW-1:0] MulXxDO;
    logic [DW-1:0] MulYxDO;
    logic [ZW-1:0] MulZxDO;
    logic [DW-1:0] MulQxDI;
    logic          OutValidxSO;
    logic          OutReadyxSI;
    logic [DW-1:0] OutQxDO;
    logic [15:0]   OpCountxDO;
    logic          BusyxSO;

    modport slave (
        input  InValidxSI, InXxDI, InYxDI, RandValidxSI, RandZxDI, MulQxDI, OutReadyxSI,
        output InReadyxSO, RandReadyxSO, MulXxDO, MulYxDO, MulZxDO, OutValidxSO, OutQxDO,
               OpCountxDO, BusyxSO
    );

    modport master (
        output InValidxSI, InXxDI, InYxDI, RandValidxSI, RandZxDI, MulQxDI, OutReadyxSI,
        input  InReadyxSO, RandReadyxSO, MulXxDO, MulYxDO, MulZxDO, OutValidxSO, OutQxDO,
               OpCountxDO, BusyxSO
    );
endinterface

// File: rtl/shared_sqscmul_seq.sv
// Single-slot sequencer feeding a shared square-scale-multiply datapath (IDLE/ISSUE/CAPTURE/OUT).
// Optional macro SQSC_ZERO_IDLE_EN zeroes the Mul* outputs outside the ISSUE cycle.
module shared_sqscmul_seq #(
    parameter int SHARES = 4
) (
    input logic                  ClkxCI,
    input logic                  RstxBI,
    shared_sqscmul_seq_if.slave  bus
);
    localparam int DW = 4 * SHARES;
    localparam int ZW = 2 * SHARES * (SHARES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] x_p0, y_p0;
    logic [ZW-1:0] z_p0;
    logic [DW-1:0] q_p1;
    logic [15:0]   op_count;
    logic          out_hs, slot_free, accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Slot frees either when idle or when the pending result leaves on this edge.
    always_comb begin
        out_hs    = (state_q == OUT) && bus.OutReadyxSI;
        slot_free = (state_q == IDLE) || out_hs;
        accept    = slot_free && bus.InValidxSI && bus.RandValidxSI;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = OUT;
            OUT:     if (accept) state_d = ISSUE;
                     else if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Issue stage: operands and randomness are taken together so a Z word serves one operation.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            x_p0 <= '0;
            y_p0 <= '0;
            z_p0 <= '0;
        end else if (accept) begin
            x_p0 <= bus.InXxDI;
            y_p0 <= bus.InYxDI;
            z_p0 <= bus.RandZxDI;
        end
`ifdef SQSC_ZERO_IDLE_EN
        else if (state_q == ISSUE) begin
            x_p0 <= '0;
            y_p0 <= '0;
            z_p0 <= '0;
        end
`endif
    end

    // Result stage: datapath output is valid during CAPTURE and held until taken.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            q_p1     <= '0;
            op_count <= '0;
        end else begin
            if (state_q == CAPTURE) q_p1 <= bus.MulQxDI;
            if (out_hs)             op_count <= sat_inc(op_count);
        end
    end

    assign bus.InReadyxSO   = RstxBI && slot_free && bus.RandValidxSI;
    assign bus.RandReadyxSO = RstxBI && slot_free && bus.InValidxSI;
    assign bus.MulXxDO      = x_p0;
    assign bus.MulYxDO      = y_p0;
    assign bus.MulZxDO      = z_p0;
    assign bus.OutValidxSO  = (state_q == OUT);
    assign bus.OutQxDO      = q_p1;
    assign bus.OpCountxDO   = op_count;
    assign bus.BusyxSO      = (state_q != IDLE);
endmodule

// File: tb/tb_shared_sqscmul_seq.sv
// Randomised bench for shared_sqscmul_seq with a transaction-level model and a 1-cycle XOR-fold datapath stub.
// Works for both the default build and SQSC_ZERO_IDLE_EN.
module tb_shared_sqscmul_seq;
    localparam int SHARES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    shared_sqscmul_seq_if #(.SHARES(SHARES)) bus ();

    shared_sqscmul_seq #(.SHARES(SHARES)) dut (
        .ClkxCI (clk),
        .RstxBI (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fold(input logic [15:0] x, input logic [15:0] y, input logic [23:0] z);
        return x ^ y ^ z[15:0] ^ {8'h00, z[23:16]};
    endfunction

    // Datapath stub: registers its result one edge after sampling Mul*.
    always @(posedge clk) bus.MulQxDI <= fold(bus.MulXxDO, bus.MulYxDO, bus.MulZxDO);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one slot, result visible two edges after acceptance.
    logic [15:0] exp_q[$];
    bit          m_busy = 0;
    int          m_age = 0;
    int          m_hs = 0;
    int          offset = 0;
    bit          m_ohs, m_acc;
    logic [15:0] m_x = '0, m_y = '0;
    logic [23:0] m_z = '0;
    int          rand_hs_dut = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_hs = 0;
            m_x = '0; m_y = '0; m_z = '0;
            exp_q.delete();
        end else begin
            m_ohs = m_busy && (m_age >= 2) && bus.OutReadyxSI;
            m_acc = bus.InValidxSI && bus.RandValidxSI && (!m_busy || m_ohs);
            if (m_ohs) begin
                void'(exp_q.pop_front());
                m_hs++;
                m_busy = 0;
            end else if (m_busy && m_age < 2) begin
                m_age++;
            end
            if (m_acc) begin
                exp_q.push_back(fold(bus.InXxDI, bus.InYxDI, bus.RandZxDI));
                m_x = bus.InXxDI; m_y = bus.InYxDI; m_z = bus.RandZxDI;
                m_busy = 1;
                m_age = 0;
            end
        end
    end

    always @(posedge clk) if (rst_n && bus.RandValidxSI && bus.RandReadyxSO) rand_hs_dut++;

    // Compare process on the falling edge.
    always @(negedge clk) begin
        logic        ev, free;
        int          cnt;
        logic [15:0] ex, ey;
        logic [23:0] ez;
        ev   = rst_n && m_busy && (m_age >= 2);
        free = !m_busy || (m_age >= 2 && bus.OutReadyxSI);
        cnt  = m_hs + offset;
        if (cnt > 65535) cnt = 65535;
`ifdef SQSC_ZERO_IDLE_EN
        ex = (m_busy && m_age == 0) ? m_x : '0;
        ey = (m_busy && m_age == 0) ? m_y : '0;
        ez = (m_busy && m_age == 0) ? m_z : '0;
`else
        ex = m_x; ey = m_y; ez = m_z;
`endif
        check("out_valid", bus.OutValidxSO, ev);
        check("busy", bus.BusyxSO, rst_n && m_busy);
        check("in_ready", bus.InReadyxSO, rst_n && bus.RandValidxSI && free);
        check("rand_ready", bus.RandReadyxSO, rst_n && bus.InValidxSI && free);
        check("op_count", bus.OpCountxDO, 64'(cnt));
        check("mul_x", bus.MulXxDO, ex);
        check("mul_y", bus.MulYxDO, ey);
        check("mul_z", bus.MulZxDO, ez);
        if (ev && exp_q.size() > 0) check("out_q", bus.OutQxDO, exp_q[0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit iv, input bit rv, input logic [15:0] x, input logic [15:0] y, input logic [23:0] z);
        bus.InValidxSI = iv; bus.RandValidxSI = rv;
        bus.InXxDI = x; bus.InYxDI = y; bus.RandZxDI = z;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   16'($urandom), 16'($urandom), 24'($urandom));
            bus.OutReadyxSI = $urandom_range(0, 2) != 0;
            tick();
        end
    endtask

    task automatic one_op(input logic [15:0] x);
        set_in(1, 1, x, ~x, 24'h5A0F33);
        bus.OutReadyxSI = 1;
        tick();
        set_in(0, 0, '0, '0, '0);
        repeat (3) tick();
    endtask

    initial begin
        logic [15:0] held;
        int          rh0;
        set_in(1, 1, 16'hFFFF, 16'hFFFF, 24'hFFFFFF);
        bus.OutReadyxSI = 1;
        repeat (2) tick();
        @(negedge clk);
        #1;
        check("rst_in_ready", bus.InReadyxSO, 0);
        check("rst_rand_ready", bus.RandReadyxSO, 0);
        check("rst_busy", bus.BusyxSO, 0);
        check("rst_mul_x", bus.MulXxDO, 0);
        check("rst_out_q", bus.OutQxDO, 0);

        // Single literal operation, accepted on the first edge after reset release.
        set_in(1, 1, 16'h1234, 16'h00F0, 24'hA5A5A5);
        rst_n = 1;
        tick();
        set_in(0, 0, '0, '0, '0);
        @(negedge clk); check("lit_issue_valid", bus.OutValidxSO, 0);
        tick();
        @(negedge clk); check("lit_capture_valid", bus.OutValidxSO, 0);
        tick();
        @(negedge clk);
        check("lit_out_valid", bus.OutValidxSO, 1);
        check("lit_out_q", bus.OutQxDO, 16'hB7C4);
        tick();
        @(negedge clk); check("lit_count", bus.OpCountxDO, 1);

        // Randomness stall.
        #1;
        set_in(1, 0, 16'hBEEF, 16'h0102, 24'h123456);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); check("stall_in_ready", bus.InReadyxSO, 0);
            tick();
        end
        rh0 = rand_hs_dut;
        bus.RandValidxSI = 1;
        @(negedge clk); check("stall_in_ready_go", bus.InReadyxSO, 1);
        tick();
        set_in(0, 0, '0, '0, '0);
        repeat (4) tick();
        check("stall_rand_hs", 64'(rand_hs_dut - rh0), 1);

        // Back-pressure with a same-edge handoff.
        bus.OutReadyxSI = 0;
        set_in(1, 1, 16'hC3C3, 16'h0F0F, 24'h00FF00);
        tick();
        set_in(0, 0, '0, '0, '0);
        repeat (2) tick();
        held = 16'hC3C3 ^ 16'h0F0F ^ 16'hFF00 ^ 16'h0000;
        set_in(1, 1, 16'h7777, 16'h1111, 24'h010101);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_q", bus.OutQxDO, held);
            check("bp_in_ready", bus.InReadyxSO, 0);
            tick();
        end
        bus.OutReadyxSI = 1;
        tick();
        @(negedge clk);
        check("bp_handoff_busy", bus.BusyxSO, 1);
        check("bp_handoff_valid", bus.OutValidxSO, 0);
        #1;
        set_in(0, 0, '0, '0, '0);
        repeat (3) tick();

        // Reset during ISSUE.
        set_in(1, 1, 16'hAAAA, 16'h5555, 24'hF0F0F0);
        tick();
        set_in(0, 0, '0, '0, '0);
        #2 rst_n = 0;
        #1;
        check("midrst_valid", bus.OutValidxSO, 0);
        check("midrst_busy", bus.BusyxSO, 0);
        check("midrst_count", bus.OpCountxDO, 0);
        check("midrst_mul_x", bus.MulXxDO, 0);
        check("midrst_mul_z", bus.MulZxDO, 0);
        @(negedge clk);
        #1 rst_n = 1;

        rand_cycles(300);

        // Saturation.
        set_in(0, 0, '0, '0, '0);
        bus.OutReadyxSI = 1;
        repeat (4) tick();
        @(negedge clk);
        #1;
        force dut.op_count = 16'hFFFE;
        offset = 65534 - m_hs;
        #1;
        release dut.op_count;
        tick();
        one_op(16'h0F0F);
        check("sat_first", bus.OpCountxDO, 16'hFFFF);
        one_op(16'hF00D);
        check("sat_hold", bus.OpCountxDO, 16'hFFFF);

        rand_cycles(300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shared_sqscmul_seq.md
SHARED_SQSCMUL_SEQ -- requirements
Module: shared_sqscmul_seq

Interface
REQ-001 SHALL have parameter SHARES, default 4, number of Boolean shares (≥2).
REQ-002 SHALL have ports (name direction width meaning), one per line:
- ClkxCI  in  1  clock; all state updates on rising edge.
- RstxBI  in  1  reset; asynchronous, active-low.
- InValidxSI  in  1  operand pair valid.
- InReadyxSO  out  1  operand pair accepted.
- InXxDI  in  4*SHARES  shared X operand.
- InYxDI  in  4*SHARES  shared Y operand.
- RandValidxSI  in  1  fresh randomness word valid.
- RandReadyxSO  out  1  randomness word consumed.
- RandZxDI  in  2*SHARES*(SHARES-1)  fresh randomness.
- MulXxDO  out  4*SHARES  X to the shared square-scale-multiply datapath.
- MulYxDO  out  4*SHARES  Y to the datapath.
- MulZxDO  out  2*SHARES*(SHARES-1)  Z to the datapath.
- MulQxDI  in  4*SHARES  datapath result; valid one edge after Mul* are sampled.
- OutValidxSO  out  1  result valid.
- OutReadyxSI  in  1  result taken.
- OutQxDO  out  4*SHARES  shared result.
- OpCountxDO  out  16  completed operations.
- BusyxSO  out  1  state ≠ IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, CAPTURE, OUT; exactly one operation in flight.
REQ-004 Accept (joint handshake) SHALL occur on an edge where InValidxSI=1, RandValidxSI=1, and state=IDLE, or state=OUT with OutReadyxSI=1.
REQ-005 InReadyxSO SHALL be 1 iff the accept condition holds excluding InValidxSI.
REQ-006 RandReadyxSO SHALL be 1 iff the accept condition holds excluding RandValidxSI.
REQ-007 Operand and randomness SHALL never be consumed separately; a randomness word SHALL drive exactly one operation.
REQ-008 On accept, InXxDI/InYxDI/RandZxDI SHALL be registered into issue registers driving MulXxDO/MulYxDO/MulZxDO; state→ISSUE.
REQ-009 ISSUE SHALL last one cycle (datapath samples Mul*), then →CAPTURE.
REQ-010 In CAPTURE, MulQxDI SHALL be registered into OutQxDO at the edge; state→OUT.
REQ-011 OUT SHALL assert OutValidxSO=1 and hold OutQxDO stable until OutReadyxSI=1.
REQ-012 OUT with OutReadyxSI=1: →ISSUE if accept occurs on the same edge (REQ-004), else →IDLE.
REQ-013 Latency SHALL be 3 edges from accept to OutValidxSO=1; peak throughput one result per 3 cycles.
REQ-014 Mul* SHALL remain stable during CAPTURE and OUT (last issued values) unless REQ-021 applies.
REQ-015 OpCountxDO SHALL increment on each output handshake, saturating at 16'hFFFF.
REQ-016 OutValidxSO SHALL be 0 in IDLE, ISSUE, CAPTURE.

Reset
REQ-017 RstxBI=0 SHALL asynchronously force state IDLE, clear all issue/output registers, OutValidxSO=0, OpCountxDO=0.
REQ-018 During reset, InReadyxSO=RandReadyxSO=0, BusyxSO=0, MulXxDO=MulYxDO=MulZxDO=0, OutQxDO=0.
REQ-019 Reset mid-operation SHALL discard the in-flight operation; no output handshake for it.
REQ-020 First accept SHALL be possible on the first rising edge after RstxBI deasserts.

Configuration
REQ-021 With SQSC_ZERO_IDLE_EN defined, MulXxDO/MulYxDO/MulZxDO SHALL be driven all-zero in every state except ISSUE (issue registers cleared on leaving ISSUE); without it, REQ-014 holds.
REQ-022 SQSC_ZERO_IDLE_EN SHALL NOT change handshake timing, latency, or OutQxDO values.

Verification (bench uses 1-cycle registered model of datapath: Q = X^Y^Z-fold stub)
REQ-023 Reset: RstxBI low mid-ISSUE -> same cycle OutValidxSO=0, BusyxSO=0, OpCountxDO=0, Mul*=0.
REQ-024 Single op: InX=16'h1234, InY=16'h00F0, Z=24'hA5A5A5, both valid at edge 0, OutReady=1 -> OutValid=1 after edge 3, OutQ=model result, OpCount=1.
REQ-025 Randomness stall: InValid=1, RandValid=0 for 5 cycles -> InReady=0, no accept; RandValid=1 at cycle 6 -> accept that edge, exactly one Rand handshake.
REQ-026 Back-pressure: OutReady=0 for 10 cycles -> OutQ stable, InReady=0; OutReady=1 with both valid -> same-edge output handshake and accept, state→ISSUE.
REQ-027 Saturation: preload 65535 completions (force) then one more op -> OpCountxDO stays 16'hFFFF.
REQ-028 With SQSC_ZERO_IDLE_EN: Mul* nonzero only in ISSUE cycles; results identical to build without macro for 100 random ops.
